// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / fetch-control stage.
package pc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

  // Default PC width, matched to the immediate/branch-target lookup table.
  localparam int PC_W_DEF = 12;
  // Relative branch offsets are 8-bit two's complement.
  localparam int OFF_W    = 8;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: hold, absolute/relative branch, or PC+1.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int PC_width = PC_W_DEF
) (
  input  logic [PC_width-1:0] pc_i,
  input  logic                hold_i,
  input  logic                branch_en_i,
  input  logic                branch_abs_i,
  input  logic [PC_width-1:0] target_i,
  output logic [PC_width-1:0] pc_next_o
);

  logic [PC_width-1:0] off_sext;

  // Only the low byte of target carries a relative offset; sums wrap naturally.
  assign off_sext = {{(PC_width-OFF_W){target_i[OFF_W-1]}}, target_i[OFF_W-1:0]};

  always_comb begin
    pc_next_o = pc_i + PC_width'(1);
    if (hold_i)
      pc_next_o = pc_i;
    else if (branch_en_i)
      pc_next_o = branch_abs_i ? target_i : (pc_i + off_sext);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control: start/halt sequencing, branch flush, retire count.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int PC_width  = PC_W_DEF,
  parameter int CNT_width = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 branch_en,
  input  logic                 branch_abs,
  input  logic [PC_width-1:0]  target,
  input  logic                 stall,
  input  logic                 halt_req,
  output logic [PC_width-1:0]  PC,
  output logic                 fetch_valid,
  output logic                 flush,
  output logic                 Done,
  output logic [CNT_width-1:0] instr_count
);

  fetch_state_t         state_q, state_d;
  logic [PC_width-1:0]  pc_q, pc_d, pc_nxt;
  logic                 flush_q, flush_d;
  logic [CNT_width-1:0] cnt_q, cnt_d;

  pc_next_calc #(.PC_width(PC_width)) u_next (
    .pc_i         (pc_q),
    .hold_i       (halt_req | stall),
    .branch_en_i  (branch_en),
    .branch_abs_i (branch_abs),
    .target_i     (target),
    .pc_next_o    (pc_nxt)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        pc_d = pc_nxt;
        // The halt instruction itself retires; the count sticks at all-ones.
        if (!stall && cnt_q != '1)
          cnt_d = cnt_q + CNT_width'(1);
        flush_d = branch_en && !halt_req && !stall;
        if (halt_req)
          state_d = HALTED;
      end
      HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PC          = pc_q;
  assign flush       = flush_q;
  assign Done        = (state_q == HALTED);
  assign instr_count = cnt_q;
  assign fetch_valid = (state_q == RUN) && !stall;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed plan steps plus random traffic vs. a reference model.
module tb_pc_fetch_ctrl;

  localparam int PW = 12;
  localparam int CW = 8;
  localparam int PMASK = (1 << PW) - 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset, Start, branch_en, branch_abs, stall, halt_req;
  logic [PW-1:0] target;
  logic [PW-1:0] PC;
  logic          fetch_valid, flush, Done;
  logic [CW-1:0] instr_count;

  int total = 0;
  int bad   = 0;

  // Reference model: running/done flags, integer PC and count.
  bit m_run, m_done, m_flush;
  int m_pc, m_cnt;

  pc_fetch_ctrl #(.PC_width(PW), .CNT_width(CW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .branch_en   (branch_en),
    .branch_abs  (branch_abs),
    .target      (target),
    .stall       (stall),
    .halt_req    (halt_req),
    .PC          (PC),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .Done        (Done),
    .instr_count (instr_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic signed [7:0] toff;
    int off;
    toff = target[7:0];
    off  = toff;
    if (Reset) begin
      m_run = 0; m_done = 0; m_flush = 0; m_pc = 0; m_cnt = 0;
    end else if (!m_run) begin
      m_flush = 0;
      if (Start) begin
        m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
      end
    end else begin
      m_flush = 0;
      if (!stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (halt_req) begin
        m_run = 0; m_done = 1;
      end else if (!stall) begin
        if (branch_en) begin
          m_pc    = branch_abs ? int'(target) : ((m_pc + off) & PMASK);
          m_flush = 1;
        end else begin
          m_pc = (m_pc + 1) & PMASK;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PC"},    32'(PC),          32'(m_pc));
    chk({tag, ".fv"},    32'(fetch_valid), 32'(m_run && !stall));
    chk({tag, ".flush"}, 32'(flush),       32'(m_flush));
    chk({tag, ".Done"},  32'(Done),        32'(m_done));
    chk({tag, ".cnt"},   32'(instr_count), 32'(m_cnt));
  endtask

  task automatic step(input bit r, input bit s, input bit be, input bit ba,
                      input logic [PW-1:0] t, input bit st, input bit h, input string tag);
    Reset = r; Start = s; branch_en = be; branch_abs = ba; target = t;
    stall = st; halt_req = h;
    model_edge();
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  task automatic plain(input string tag);
    step(0, 0, 0, 0, '0, 0, 0, tag);
  endtask

  initial begin
    Reset = 1; Start = 0; branch_en = 0; branch_abs = 0; target = '0;
    stall = 0; halt_req = 0;
    m_run = 0; m_done = 0; m_flush = 0; m_pc = 0; m_cnt = 0;

    // Reset held 3 cycles with other inputs toggling.
    for (int i = 0; i < 3; i++)
      step(1, i[0], 1, 1, 12'h3b, 0, 1, "reset");
    chk("reset.PC0", 32'(PC), 32'h0);
    chk("reset.state_idle_fv", 32'(fetch_valid), 32'h0);
    step(0, 0, 1, 1, 12'h55, 0, 1, "idle_ignore");

    step(0, 1, 0, 0, '0, 0, 0, "start");
    chk("start.PC0", 32'(PC), 32'h0);
    chk("start.fv", 32'(fetch_valid), 32'h1);
    for (int i = 0; i < 5; i++) plain("seq");
    chk("seq.PC5", 32'(PC), 32'h5);
    chk("seq.cnt5", 32'(instr_count), 32'h5);
    for (int i = 0; i < 3; i++) plain("seq");
    chk("seq.PC8", 32'(PC), 32'h8);

    // Relative branch -4 from 8, then absolute to 'h3b.
    step(0, 0, 1, 0, 12'h0fc, 0, 0, "rel_br");
    chk("rel_br.PC4", 32'(PC), 32'h4);
    chk("rel_br.flush1", 32'(flush), 32'h1);
    plain("rel_after");
    chk("rel_after.flush0", 32'(flush), 32'h0);
    step(0, 0, 1, 1, 12'h03b, 0, 0, "abs_br");
    chk("abs_br.PC3b", 32'(PC), 32'h3b);
    plain("abs_after");

    // Wrap cases.
    step(0, 0, 1, 1, 12'hfff, 0, 0, "to_fff");
    plain("wrap_inc");
    chk("wrap_inc.PC0", 32'(PC), 32'h0);
    step(0, 0, 1, 1, 12'h002, 0, 0, "to_2");
    step(0, 0, 1, 0, 12'h0fc, 0, 0, "wrap_rel");
    chk("wrap_rel.PCffe", 32'(PC), 32'hffe);

    // Stall 3 cycles at PC=7, branch on the first.
    step(0, 0, 1, 1, 12'h007, 0, 0, "to_7");
    plain("settle7");
    step(0, 0, 1, 1, 12'h007, 0, 0, "to_7b");
    step(0, 0, 1, 0, 12'h040, 1, 0, "stall0");
    chk("stall0.PC7", 32'(PC), 32'h7);
    chk("stall0.fv0", 32'(fetch_valid), 32'h0);
    step(0, 0, 0, 0, '0, 1, 0, "stall1");
    step(0, 0, 0, 0, '0, 1, 0, "stall2");
    chk("stall2.PC7", 32'(PC), 32'h7);
    chk("stall2.flush0", 32'(flush), 32'h0);

    // Halt with simultaneous branch at 'h20.
    step(0, 0, 1, 1, 12'h020, 0, 0, "to_20");
    step(0, 0, 1, 1, 12'h0aa, 0, 1, "halt");
    chk("halt.Done", 32'(Done), 32'h1);
    chk("halt.PC20", 32'(PC), 32'h20);
    chk("halt.flush0", 32'(flush), 32'h0);
    step(0, 0, 1, 0, 12'h011, 1, 1, "halted_hold");
    step(0, 1, 0, 0, '0, 0, 0, "restart");
    chk("restart.PC0", 32'(PC), 32'h0);
    chk("restart.Done0", 32'(Done), 32'h0);
    chk("restart.cnt0", 32'(instr_count), 32'h0);
    step(0, 1, 0, 0, '0, 0, 0, "start_in_run");

    // Reset mid-run at 'h15 while a branch would set flush.
    step(0, 0, 1, 1, 12'h015, 0, 0, "to_15");
    step(1, 0, 1, 1, 12'h030, 0, 0, "mid_reset");
    chk("mid_reset.PC0", 32'(PC), 32'h0);
    chk("mid_reset.flush0", 32'(flush), 32'h0);
    chk("mid_reset.cnt0", 32'(instr_count), 32'h0);
    chk("mid_reset.fv0", 32'(fetch_valid), 32'h0);

    // Counter saturation.
    step(0, 1, 0, 0, '0, 0, 0, "sat_start");
    for (int i = 0; i < CMAX + 20; i++) plain("sat");
    chk("sat.cnt_max", 32'(instr_count), 32'(CMAX));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 35, $urandom_range(0, 1) == 1,
           PW'($urandom), $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 4, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
